stochastic_subtractor_array: RTL

Multi-channel, sequential successor to the single-bit combinational stochastic subtractor. NUM_CH channels consume one stream bit per channel per accepted cycle. The select stream is generated internally by a shared LFSR. Operating mode is runtime-selectable: bipolar scaled subtraction (MUX) or unipolar absolute difference (XOR). Each channel's output ones are counted over a BIT_LENGTH-bit stream and delivered as binary counts with a start/done handshake, sitting between the stream generators and the binary readout.

---
 rtl/stochastic_subtractor_array.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stochastic_subtractor_array.sv
// ---------------------------------------------------------------------------
// stochastic_subtractor_array
//
// Purpose:
//   A multi-channel stochastic subtractor. NUM_CH channels each take one bit
//   of stream A and one bit of stream B per accepted cycle.
//   mode 0 gives a bipolar scaled subtraction. A select stream from a shared
//   Galois LFSR drives a MUX between a[k] and ~b[k].
//   mode 1 gives a unipolar absolute difference, computed as a[k] ^ b[k].
//   Each channel counts the ones in its output stream over BIT_LENGTH
//   accepted bits. The count is reported with a start/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begins an operation (only sampled in IDLE)
//   mode       0 = bipolar MUX subtract, 1 = unipolar XOR |A-B|
//   a_bits     one stream-A bit per channel
//   b_bits     one stream-B bit per channel
//   in_valid   a_bits/b_bits valid this cycle
//   in_ready   high in RUN; a pair is consumed on in_valid && in_ready
//   y_bits     registered output bits of the last consumed pair
//   y_valid    pulses one cycle after each consumed pair
//   sel_bit    registered select bit used for the last consumed pair
//   busy       high in RUN and DONE
//   count_out  per-channel ones counts, channel k at [k*CNT_W +: CNT_W]
//   done       one-cycle pulse while count_out carries fresh results
// ---------------------------------------------------------------------------
module stochastic_subtractor_array #(
    parameter int          NUM_CH     = 4,
    parameter int          BIT_LENGTH = 128,
    parameter int          CNT_W      = $clog2(BIT_LENGTH + 1),
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [NUM_CH-1:0]       a_bits,
    input  logic [NUM_CH-1:0]       b_bits,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH-1:0]       y_bits,
    output logic                    y_valid,
    output logic                    sel_bit,
    output logic                    busy,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic                    done
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         mode_q;
    logic [15:0]                  lfsr;
    logic [CNT_W-1:0]             bit_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] ones;
    logic [NUM_CH-1:0]            y_now;
    logic                         consume;
    logic                         last_bit;

    assign consume  = (state == RUN) && in_valid;
    assign last_bit = consume && (bit_cnt == CNT_W'(BIT_LENGTH - 1));

    // The select bit is the current LFSR LSB. It is used before the LFSR advances.
    always_comb begin
        y_now = '0;
        if (mode_q) begin
            y_now = a_bits ^ b_bits;
        end else begin
            y_now = lfsr[0] ? a_bits : ~b_bits;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // count_out is loaded on the final consume, so it already holds the final
    // counts during the DONE cycle. It keeps them until the next operation ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            lfsr      <= LFSR_SEED;
            bit_cnt   <= '0;
            ones      <= '0;
            y_bits    <= '0;
            y_valid   <= 1'b0;
            sel_bit   <= 1'b0;
            count_out <= '0;
        end else begin
            y_valid <= 1'b0;
            if (state == IDLE && start) begin
                mode_q  <= mode;
                lfsr    <= LFSR_SEED;
                bit_cnt <= '0;
                ones    <= '0;
            end else if (consume) begin
                y_bits  <= y_now;
                sel_bit <= lfsr[0];
                y_valid <= 1'b1;
                bit_cnt <= bit_cnt + 1'b1;
                lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
                for (int k = 0; k < NUM_CH; k++) begin
                    ones[k] <= ones[k] + CNT_W'(y_now[k]);
                    if (last_bit) begin
                        count_out[k*CNT_W +: CNT_W] <= ones[k] + CNT_W'(y_now[k]);
                    end
                end
            end
        end
    end

endmodule
